// File: rtl/lab4_freq_div_ctrl.sv
// Run/stop sequencer for the lab 4 divided clock: one prescaler, two selectable
// ratios switched only at period boundaries, tick/clk_out generation and burst mode.
module lab4_freq_div_ctrl #(
  parameter int DIV_FAST = 10000000,
  parameter int DIV_SLOW = 50000000,
  parameter int CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       speed,
  input  logic       burst_en,
  input  logic [3:0] burst_len,
  output logic       tick,
  output logic       clk_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // The divisor is kept as (ratio - 1) so the terminal compare is a plain equality
  // and the register never needs more than CNT_W bits.
  localparam logic [CNT_W-1:0] FAST_M1 = CNT_W'(DIV_FAST - 1);
  localparam logic [CNT_W-1:0] SLOW_M1 = CNT_W'(DIV_SLOW - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] pre, pre_next;
  logic [CNT_W-1:0] div_m1, div_m1_next;
  logic [4:0]       tcnt, tcnt_next, tcnt_inc;
  logic [4:0]       len_q, len_next;
  logic             burst_q, burst_next;
  logic             tick_next, clk_out_next, busy_next, done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pre     <= '0;
      div_m1  <= FAST_M1;
      tcnt    <= '0;
      len_q   <= '0;
      burst_q <= 1'b0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      pre     <= pre_next;
      div_m1  <= div_m1_next;
      tcnt    <= tcnt_next;
      len_q   <= len_next;
      burst_q <= burst_next;
      tick    <= tick_next;
      clk_out <= clk_out_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

  assign tcnt_inc = (tcnt == 5'd16) ? tcnt : tcnt + 5'd1;

  always_comb begin
    state_next   = state;
    pre_next     = pre;
    div_m1_next  = div_m1;
    tcnt_next    = tcnt;
    len_next     = len_q;
    burst_next   = burst_q;
    tick_next    = 1'b0;
    clk_out_next = clk_out;
    done_next    = 1'b0;

    case (state)
      IDLE: begin
        pre_next     = '0;
        clk_out_next = 1'b0;
        if (start && !stop) begin
          div_m1_next = speed ? SLOW_M1 : FAST_M1;
          burst_next  = burst_en;
          len_next    = (burst_len == 4'd0) ? 5'd16 : {1'b0, burst_len};
          tcnt_next   = '0;
          state_next  = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_next   = IDLE;
          pre_next     = '0;
          clk_out_next = 1'b0;
        end else if (pre == div_m1) begin
          pre_next     = '0;
          tick_next    = 1'b1;
          clk_out_next = ~clk_out;
          tcnt_next    = tcnt_inc;
          div_m1_next  = speed ? SLOW_M1 : FAST_M1;
          if (burst_q && (tcnt_inc == len_q)) state_next = DONE;
        end else begin
          pre_next = pre + CNT_W'(1);
        end
      end
      DONE: begin
        done_next    = 1'b1;
        pre_next     = '0;
        clk_out_next = 1'b0;
        state_next   = IDLE;
      end
      default: begin
        state_next   = IDLE;
        pre_next     = '0;
        clk_out_next = 1'b0;
      end
    endcase

    // busy stays up through the DONE cycle and drops together with the done pulse
    busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_lab4_freq_div_ctrl.sv
// Scoreboard bench for lab4_freq_div_ctrl: expected tick/done events are derived from
// the speed plan with plain arithmetic and compared by an independent monitor.
module tb_lab4_freq_div_ctrl;
  localparam int DF = 4;
  localparam int DS = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       speed = 1'b0;
  logic       burst_en = 1'b0;
  logic [3:0] burst_len = 4'd0;
  logic       tick, clk_out, busy, done;

  lab4_freq_div_ctrl #(.DIV_FAST(DF), .DIV_SLOW(DS), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .speed(speed),
    .burst_en(burst_en), .burst_len(burst_len),
    .tick(tick), .clk_out(clk_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;   // 0 = tick, 1 = done
    int at;     // cycle number (posedge count) in which the pulse is visible
    int co;     // clk_out value in that cycle
  } ev_t;
  ev_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic see_event(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_%s at cycle %0d: got pulse, expected none",
               (kind == 0) ? "tick" : "done", cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.at);
      check("event_clk_out", int'(clk_out), e.co);
      $display("event kind=%0d cycle=%0d clk_out=%0d", kind, cyc, clk_out);
    end
  endtask

  // Monitor: every observed pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tick) see_event(0);
      if (done) see_event(1);
    end
  end

  // One run from start to stop (continuous) or to done (burst).
  // spd_mode: 0 = constant spd0, 1 = flip once at chg_at, 2 = random changes.
  task automatic run_case(input bit b_en, input logic [3:0] blen, input int ncyc,
                          input bit spd0, input int spd_mode, input int chg_at);
    int spd[];
    int n, t, k, d, done_t, e0, len;
    ev_t e;
    spd = new[ncyc + 220];
    for (int i = 0; i < ncyc + 220; i++) begin
      if (spd_mode == 1) spd[i] = (i >= chg_at) ? int'(!spd0) : int'(spd0);
      else if (spd_mode == 2) spd[i] = (i == 0) ? int'(spd0)
                                      : (($urandom_range(0, 5) == 0) ? 1 - spd[i-1] : spd[i-1]);
      else spd[i] = int'(spd0);
    end

    // Reference: each period length is set by the speed seen at its starting edge.
    e0 = cyc + 1;
    n = b_en ? ((blen == 4'd0) ? 16 : int'(blen)) : 0;
    t = 0; k = 0; done_t = -1;
    d = spd[0] ? DS : DF;
    forever begin
      t += d;
      if (!b_en && t >= ncyc) break;
      k++;
      e.kind = 0; e.at = e0 + t; e.co = k % 2;
      exp_q.push_back(e);
      if (b_en && k == n) begin
        done_t = t + 1;
        e.kind = 1; e.at = e0 + t + 1; e.co = 0;
        exp_q.push_back(e);
        break;
      end
      d = spd[t] ? DS : DF;
    end
    $display("case burst=%0d len=%0d ncyc=%0d mode=%0d expects %0d events",
             b_en, blen, ncyc, spd_mode, exp_q.size());

    start = 1'b1; speed = spd[0][0]; burst_en = b_en; burst_len = blen;
    len = b_en ? done_t + 4 : ncyc + 3;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      start = b_en && (i == done_t);
      stop  = !b_en && (i == ncyc);
      speed = spd[i][0];
      if (i == 1) check("busy_after_start", int'(busy), 1);
      if (!b_en && i == ncyc + 1) check("busy_after_stop", int'(busy), 0);
      if (b_en && i == done_t) check("busy_in_done_cycle", int'(busy), 1);
      if (b_en && i == done_t + 1) check("busy_with_done", int'(busy), 0);
    end
    start = 1'b0; stop = 1'b0;
    check("busy_end", int'(busy), 0);
    check("clk_out_end", int'(clk_out), 0);
    check("pending_events", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_tick", int'(tick), 0);
    check("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_clk_out", int'(clk_out), 0);
    check("idle_done", int'(done), 0);

    // continuous fast run, stopped on a non-terminal cycle
    run_case(1'b0, 4'd0, 27, 1'b0, 0, 0);
    // speed change two cycles after the first tick
    run_case(1'b0, 4'd0, 40, 1'b0, 1, 6);
    // bursts of 3 and of 16
    run_case(1'b1, 4'd3, 0, 1'b0, 0, 0);
    run_case(1'b1, 4'd0, 0, 1'b0, 0, 0);
    // stop coincident with a terminal count
    run_case(1'b0, 4'd0, 8, 1'b0, 0, 0);

    // start together with stop in IDLE
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (10) @(negedge clk);
    check("start_stop_idle_busy", int'(busy), 0);

    // asynchronous reset with the prescaler at 2
    start = 1'b1; speed = 1'b0; burst_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midreset_busy", int'(busy), 0);
    check("midreset_tick", int'(tick), 0);
    check("midreset_clk_out", int'(clk_out), 0);
    check("midreset_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_case(1'b0, 4'd0, 14, 1'b0, 0, 0);

    for (int r = 0; r < 8; r++) begin
      logic [3:0] bl;
      bl = 4'($urandom_range(0, 15));
      run_case(1'($urandom_range(0, 1)), bl, int'($urandom_range(5, 60)),
               1'($urandom_range(0, 1)), 2, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lab4_freq_div_ctrl.md
# lab4_freq_div_ctrl

Run/stop sequencer for the lab 4 divided-clock datapath. It owns a single prescaler counter and starts and stops it on command. It selects one of two divide ratios, and changes the ratio only at a period boundary so the output never glitches. It emits a one-cycle `tick` enable, a 50%-duty `clk_out`, and an optional burst mode that stops automatically after a programmed number of ticks. It sits between the debounced push-button logic and the counter/display blocks that consume the slow tick.

## Interface
- `DIV_FAST`, default 10000000: prescale ratio when `speed`=0; must be ≥2.
- `DIV_SLOW`, default 50000000: prescale ratio when `speed`=1; must be ≥2.
- `CNT_W`, default 26: prescaler width; must hold max(`DIV_FAST`,`DIV_SLOW`)−1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  single-cycle request to begin running; already synchronized to `clk`.
- `stop`  in  1  single-cycle request to abort; already synchronized to `clk`.
- `speed`  in  1  ratio select: 0 = `DIV_FAST`, 1 = `DIV_SLOW`.
- `burst_en`  in  1  1 = stop after `burst_len` ticks; 0 = run continuously.
- `burst_len`  in  4  tick count for burst mode; 0 encodes 16.
- `tick`  out  1  one-cycle pulse at each period end.
- `clk_out`  out  1  toggles on every tick.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when a burst completes.

## Operation
- The FSM has three states: IDLE, RUN and DONE. All outputs are registered.
- **IDLE**
  - Prescaler is held at 0 and `clk_out` is held at 0.
  - When `start`=1 and `stop`=0, the block:
    - latches the divisor `div_q` from `speed`,
    - latches `burst_en` and `burst_len`,
    - clears the tick counter `tcnt` (5 bits),
    - enters RUN with the prescaler at 0.
- **RUN**
  - The prescaler increments by 1 each cycle.
  - When the prescaler equals `div_q`−1, the block:
    - clears the prescaler,
    - pulses `tick`,
    - toggles `clk_out`,
    - increments `tcnt`,
    - re-latches `div_q` from the current `speed`.
  - A `speed` change therefore affects only the next full period.
  - In burst mode, the terminal tick that makes `tcnt` equal the latched length (16 when `burst_len` is 0) moves the FSM to DONE.
  - `start` is ignored while in RUN.
- **DONE**
  - Lasts exactly one cycle, with `done`=1.
  - Prescaler is cleared, `clk_out` is forced to 0, and the next state is IDLE.
  - `start` is ignored in DONE.
- **Stop**
  - `stop`=1 in RUN returns to IDLE on the next edge.
  - The prescaler and `clk_out` clear, and no `tick` or `done` is generated.
  - `stop` has priority over a coincident terminal count, so no tick fires on that cycle.
  - `stop` has priority over `start` in every state.
- **Arithmetic:** the prescaler compare is an `CNT_W`-bit equality. `tcnt` saturates at 16 and never wraps.
- **Reset:** asserting `rst_n` low at any time, including mid-period, forces:
  - state IDLE,
  - prescaler 0, `tcnt` 0, `div_q` `DIV_FAST`,
  - `tick`=0, `clk_out`=0, `busy`=0, `done`=0.

## Timing
- `start` sampled at edge E0 gives `busy`=1 from E0 onward and prescaler 0 in the cycle after E0.
- The first `tick` is high in the cycle following edge E0+`div_q`. Subsequent ticks are exactly `div_q` cycles apart.
- `clk_out` period is 2×`div_q` cycles with 50% duty, as long as `speed` is stable.
- `tick`, the `clk_out` toggle and the `tcnt` increment are coincident, on the same edge.
- A burst of N ticks:
  - `done` is asserted one cycle after the Nth `tick`,
  - `busy` falls on the same edge that raises `done`,
  - the block is IDLE one cycle later.
- `stop` latency is 1 cycle, with `busy` falling on the sampling edge.

## Test plan
Benches use `DIV_FAST`=4 and `DIV_SLOW`=10.
- **Reset defaults:** apply reset, then release. All outputs must be 0 and no ticks may occur for 50 cycles without `start`.
- **Continuous fast run:** `speed`=0, `burst_en`=0, pulse `start`.
  - First tick occurs 4 cycles after the start edge, then every 4 cycles.
  - `clk_out` period is 8.
  - `busy` stays at 1.
- **Speed change mid-period:** switch `speed` 0→1 two cycles after a tick.
  - The next tick arrives 4 cycles after the previous one; the following gap is 10.
  - `clk_out` shows no glitch.
- **Burst:** `burst_en`=1, `burst_len`=3, `speed`=0.
  - Exactly 3 ticks, with `done` one cycle after the third.
  - `busy` goes 0, `clk_out` returns to 0, and a `start` pulse during DONE has no effect.
- **`burst_len`=0:** exactly 16 ticks, then `done`.
- **Simultaneous events:**
  - `stop` asserted on a terminal-count cycle gives no tick and IDLE next cycle.
  - `start` with `stop` in IDLE leaves the block in IDLE.
  - `rst_n` asserted low at prescaler 2 clears the block immediately; the next `start` yields its first tick after 4 cycles.
